// File: rtl/mmul_pkg.sv
// Shared types and phase-length constants for the systolic-array multiply controller.
package mmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_UNLOAD,
    S_DONE
  } state_t;

  localparam int DEF_N      = 4;
  localparam int FLUSH_LEN  = 2 * DEF_N;
  localparam int UNLOAD_LEN = 2 * DEF_N;
  localparam int ROW_W      = $clog2(DEF_N);

  // Flush and unload both span the skew depth on both sides of the grid.
  function automatic int phase_len(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/mmul_phase_counter.sv
// Loadable up/down phase counter with enable, hold and terminal-count flag.
module mmul_phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         hold,
  input  logic         down,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !hold) begin
      cnt <= down ? (cnt - W'(1)) : (cnt + W'(1));
    end
  end

  // Down-counting phases terminate at zero; up-counting phases at the limit.
  assign tc = down ? (cnt == '0) : (cnt == limit);

endmodule

// File: rtl/mmul_controller.sv
// Sequencer for one N x N output-stationary multiply: clear, feed, flush, unload, done.
module mmul_controller
  import mmul_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int K_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [K_WIDTH-1:0]   k_len,
  output logic                 rd_en,
  output logic [K_WIDTH-1:0]   rd_idx,
  output logic                 acc_clear,
  output logic                 array_en,
  output logic                 zero_in,
  output logic                 array_shift,
  output logic                 obuf_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_row,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int FLUSH_CYC  = phase_len(N);
  localparam int UNLOAD_CYC = phase_len(N);
  localparam int RW         = $clog2(N);
  localparam int CW         = (K_WIDTH > $clog2(UNLOAD_CYC)) ? K_WIDTH : $clog2(UNLOAD_CYC);

  localparam logic [CW-1:0] FLUSH_TOP   = CW'(FLUSH_CYC - 1);
  localparam logic [CW-1:0] U_LAST      = CW'(UNLOAD_CYC - 1);
  localparam logic [CW-1:0] U_SHIFT_MAX = CW'(UNLOAD_CYC - 2);
  localparam logic [CW-1:0] U_FIRST_ROW = CW'(N);

  state_t             state;
  logic [K_WIDTH-1:0] klen_q;
  logic               err_q;
  logic               rd_en_p1;

  logic               cnt_load;
  logic [CW-1:0]      cnt_load_val;
  logic               cnt_en;
  logic               cnt_down;
  logic [CW-1:0]      cnt_limit;
  logic [CW-1:0]      cnt;
  logic               cnt_tc;

  logic               in_feed;
  logic               in_flush;
  logic               in_unload;
  logic               stall;

  assign in_feed   = (state == S_FEED);
  assign in_flush  = (state == S_FLUSH);
  assign in_unload = (state == S_UNLOAD);

  assign cnt_en    = in_feed || in_flush || in_unload;
  assign cnt_down  = in_flush;
  assign cnt_limit = in_feed ? (CW'(klen_q) - CW'(1)) : U_LAST;

  // One counter serves all three timed phases; it is reloaded at each phase boundary.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state)
      S_CLEAR: cnt_load = 1'b1;
      S_FEED: begin
        if (cnt_tc) begin
          cnt_load     = 1'b1;
          cnt_load_val = FLUSH_TOP;
        end
      end
      S_FLUSH: begin
        if (cnt_tc) begin
          cnt_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  mmul_phase_counter #(
    .W (CW)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .hold     (stall),
    .down     (cnt_down),
    .limit    (cnt_limit),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      klen_q   <= '0;
      err_q    <= 1'b0;
      rd_en_p1 <= 1'b0;
    end else begin
      err_q    <= 1'b0;
      rd_en_p1 <= in_feed;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (k_len != '0) begin
              klen_q <= k_len;
              state  <= S_CLEAR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_CLEAR:  state <= S_FEED;
        S_FEED:   if (cnt_tc) state <= S_FLUSH;
        S_FLUSH:  if (cnt_tc) state <= S_UNLOAD;
        S_UNLOAD: if (cnt_tc && !stall) state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; out_ready gates the unload shift so a stall freezes in the same cycle.
  assign rd_en       = in_feed;
  assign rd_idx      = in_feed ? cnt[K_WIDTH-1:0] : '0;
  assign acc_clear   = (state == S_CLEAR);
  assign array_en    = rd_en_p1 || in_flush;
  assign zero_in     = in_flush && (cnt != FLUSH_TOP);
  assign out_valid   = in_unload && (cnt >= U_FIRST_ROW);
  assign stall       = out_valid && !out_ready;
  assign array_shift = in_unload && (cnt <= U_SHIFT_MAX) && !stall;
  assign obuf_en     = array_shift;
  assign out_row     = out_valid ? RW'(cnt - U_FIRST_ROW) : '0;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign err         = err_q;

endmodule

// File: tb/tb_mmul_controller.sv
// Directed bench for mmul_controller with N=4: per-cycle checks of every control output.
module tb_mmul_controller;

  localparam int N  = 4;
  localparam int KW = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [KW-1:0] k_len;
  logic          rd_en;
  logic [KW-1:0] rd_idx;
  logic          acc_clear;
  logic          array_en;
  logic          zero_in;
  logic          array_shift;
  logic          obuf_en;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_row;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks;
  int n_errors;

  mmul_controller #(
    .N       (N),
    .K_WIDTH (KW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .k_len       (k_len),
    .rd_en       (rd_en),
    .rd_idx      (rd_idx),
    .acc_clear   (acc_clear),
    .array_en    (array_en),
    .zero_in     (zero_in),
    .array_shift (array_shift),
    .obuf_en     (obuf_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s@%0d: observed %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag, input int cyc);
    chk(tag, cyc, {11'd0, rd_en, rd_idx, acc_clear, array_en, zero_in, array_shift,
                   obuf_en, out_valid, out_row, busy, done, err}, 32'd0);
  endtask

  // Called in cycle 0 (CLEAR). Checks every output through the first IDLE cycle after done.
  // st_c/st_n: cycle and length of an out_ready=0 window; sp_c: cycle of a stray start pulse.
  task automatic run_cmd(input int kl, input int st_c, input int st_n, input int sp_c, input int exp_done);
    int  last;
    int  u0;
    int  u;
    int  first_done;
    logic stl;
    logic in_un;
    last       = kl + 4*N + 1 + st_n;
    u0         = kl + 2*N + 1;
    first_done = -1;
    for (int c = 0; c <= last + 1; c++) begin
      stl       = (c >= st_c) && (c < st_c + st_n);
      out_ready = !stl;
      start     = (c == sp_c);
      k_len     = (c == sp_c) ? 8'd9 : 8'(kl);
      #2;
      if (c < st_c)              u = c - u0;
      else if (c < st_c + st_n)  u = st_c - u0;
      else                       u = c - u0 - st_n;
      in_un = (c >= u0) && (c <= u0 + 2*N - 1 + st_n);
      chk("acc_clear",   c, acc_clear,   c == 0);
      chk("rd_en",       c, rd_en,       (c >= 1) && (c <= kl));
      chk("rd_idx",      c, rd_idx,      ((c >= 1) && (c <= kl)) ? c - 1 : 0);
      chk("array_en",    c, array_en,    (c >= 2) && (c <= kl + 2*N));
      chk("zero_in",     c, zero_in,     (c >= kl + 2) && (c <= kl + 2*N));
      chk("array_shift", c, array_shift, in_un && (u <= 2*N - 2) && !stl);
      chk("obuf_en",     c, obuf_en,     in_un && (u <= 2*N - 2) && !stl);
      chk("out_valid",   c, out_valid,   in_un && (u >= N));
      chk("out_row",     c, out_row,     (in_un && (u >= N)) ? u - N : 0);
      chk("busy",        c, busy,        c <= last);
      chk("done",        c, done,        c == last);
      chk("err",         c, err,         1'b0);
      if (done === 1'b1 && first_done < 0) first_done = c;
      if (c <= last) tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("done_cycle", kl, first_done, exp_done);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    out_ready = 1'b1;
    #3;
    chk_all_zero("reset_outputs", 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_all_zero("idle_after_reset", 0);

    // Baseline command, k_len=4, no back-pressure: done in cycle 21.
    start = 1'b1;
    k_len = 8'd4;
    tick();
    run_cmd(4, 1000, 0, -1, 21);

    // Start right after done, plus a stray start during FEED that must be ignored.
    start = 1'b1;
    k_len = 8'd4;
    tick();
    run_cmd(4, 1000, 0, 2, 21);

    // Three stall cycles while row 1 is presented: done slips to cycle 24.
    tick();
    start = 1'b1;
    k_len = 8'd4;
    tick();
    run_cmd(4, 18, 3, -1, 24);

    // k_len=0 is rejected with a one-cycle err pulse.
    start = 1'b1;
    k_len = 8'd0;
    tick();
    start = 1'b0;
    #2;
    chk("err_pulse",   0, err,   1'b1);
    chk("err_busy",    0, busy,  1'b0);
    chk("err_rd_en",   0, rd_en, 1'b0);
    tick();
    #2;
    chk("err_cleared", 1, err,   1'b0);
    chk("err_busy",    1, busy,  1'b0);
    chk("err_rd_en",   1, rd_en, 1'b0);
    tick();

    // Single-beat command: done in cycle 18.
    start = 1'b1;
    k_len = 8'd1;
    tick();
    run_cmd(1, 1000, 0, -1, 18);

    // Asynchronous reset mid-FEED clears every output before the next edge.
    tick();
    start = 1'b1;
    k_len = 8'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    chk("feed_before_reset", 2, rd_en, 1'b1);
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset", 2);
    tick();
    reset = 1'b0;
    tick();
    chk_all_zero("after_reset_release", 0);

    // Same command again reproduces the baseline timeline.
    start = 1'b1;
    k_len = 8'd4;
    tick();
    run_cmd(4, 1000, 0, -1, 21);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
